// File: rtl/dispatch_rob_alloc.sv
// Dispatch-side ROB tag allocator: in-order tag assignment, registered ROB write port, occupancy tracking.
// Optional stall statistics counter is built when DISPATCH_ROB_ALLOC_STATS_EN is defined.
module dispatch_rob_alloc #(
  parameter int DISPATCH_WIDTH = 2,
  parameter int RETIRE_WIDTH   = 2,
  parameter int ROB_DEPTH      = 16,
  localparam int TAG_W         = $clog2(ROB_DEPTH),
  localparam int RC_W          = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DISPATCH_WIDTH-1:0]       in_valid,
  output logic                            in_ready,
  input  logic [DISPATCH_WIDTH*32-1:0]    in_pc,
  input  logic [DISPATCH_WIDTH*5-1:0]     in_rd,
  input  logic [DISPATCH_WIDTH-1:0]       in_rd_we,
  output logic [DISPATCH_WIDTH-1:0]       rob_wr_valid,
  output logic [DISPATCH_WIDTH*TAG_W-1:0] rob_wr_tag,
  output logic [DISPATCH_WIDTH*32-1:0]    rob_wr_pc,
  output logic [DISPATCH_WIDTH*5-1:0]     rob_wr_rd,
  output logic [DISPATCH_WIDTH-1:0]       rob_wr_rd_we,
  input  logic [RC_W-1:0]                 retire_count,
  input  logic                            flush,
  output logic [TAG_W:0]                  free_count,
  output logic [TAG_W-1:0]                tail_tag,
  output logic [31:0]                     stall_cycles
);

  localparam logic [TAG_W:0] DEPTH_C = (TAG_W+1)'(ROB_DEPTH);
  localparam logic [TAG_W:0] GROUP_C = (TAG_W+1)'(DISPATCH_WIDTH);

  logic [TAG_W-1:0]                tail_q, tail_d;
  logic [TAG_W:0]                  occ_q, occ_d;
  logic [DISPATCH_WIDTH-1:0]       rob_wr_valid_q, rob_wr_valid_d;
  logic [DISPATCH_WIDTH*TAG_W-1:0] rob_wr_tag_q, rob_wr_tag_d;
  logic [DISPATCH_WIDTH*32-1:0]    rob_wr_pc_q, rob_wr_pc_d;
  logic [DISPATCH_WIDTH*5-1:0]     rob_wr_rd_q, rob_wr_rd_d;
  logic [DISPATCH_WIDTH-1:0]       rob_wr_rd_we_q, rob_wr_rd_we_d;

  logic           xfer;
  logic           prefix_run;
  logic [TAG_W:0] alloc_n;
  logic [TAG_W+1:0] occ_sum;
  logic [TAG_W+1:0] ret_ext;

  assign free_count = DEPTH_C - occ_q;
  // Depends only on registered occupancy and flush; no path from in_valid or retire_count.
  assign in_ready   = !flush && (free_count >= GROUP_C);
  assign xfer       = in_ready && in_valid[0];
  assign tail_tag   = tail_q;

  // Only the contiguous low-order prefix of in_valid allocates.
  always_comb begin
    alloc_n    = '0;
    prefix_run = 1'b1;
    for (int i = 0; i < DISPATCH_WIDTH; i++) begin
      if (prefix_run && in_valid[i]) begin
        alloc_n = alloc_n + (TAG_W+1)'(1);
      end else begin
        prefix_run = 1'b0;
      end
    end
    if (!xfer) begin
      alloc_n = '0;
    end
  end

  always_comb begin
    occ_sum = {1'b0, occ_q} + {1'b0, alloc_n};
    ret_ext = (TAG_W+2)'(retire_count);
    if (flush) begin
      occ_d = '0;
    end else if (ret_ext > occ_sum) begin
      occ_d = '0;
    end else begin
      occ_d = (TAG_W+1)'(occ_sum - ret_ext);
    end
  end

  always_comb begin
    if (flush) begin
      tail_d = '0;
    end else begin
      tail_d = tail_q + alloc_n[TAG_W-1:0];
    end
  end

  always_comb begin
    rob_wr_valid_d = '0;
    rob_wr_tag_d   = rob_wr_tag_q;
    rob_wr_pc_d    = rob_wr_pc_q;
    rob_wr_rd_d    = rob_wr_rd_q;
    rob_wr_rd_we_d = rob_wr_rd_we_q;
    if (xfer) begin
      for (int i = 0; i < DISPATCH_WIDTH; i++) begin
        rob_wr_valid_d[i]              = ((TAG_W+1)'(i) < alloc_n);
        rob_wr_tag_d[i*TAG_W +: TAG_W] = tail_q + TAG_W'(i);
      end
      rob_wr_pc_d    = in_pc;
      rob_wr_rd_d    = in_rd;
      rob_wr_rd_we_d = in_rd_we;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_q         <= '0;
      occ_q          <= '0;
      rob_wr_valid_q <= '0;
      rob_wr_tag_q   <= '0;
      rob_wr_pc_q    <= '0;
      rob_wr_rd_q    <= '0;
      rob_wr_rd_we_q <= '0;
    end else begin
      tail_q         <= tail_d;
      occ_q          <= occ_d;
      rob_wr_valid_q <= rob_wr_valid_d;
      rob_wr_tag_q   <= rob_wr_tag_d;
      rob_wr_pc_q    <= rob_wr_pc_d;
      rob_wr_rd_q    <= rob_wr_rd_d;
      rob_wr_rd_we_q <= rob_wr_rd_we_d;
    end
  end

  assign rob_wr_valid = rob_wr_valid_q;
  assign rob_wr_tag   = rob_wr_tag_q;
  assign rob_wr_pc    = rob_wr_pc_q;
  assign rob_wr_rd    = rob_wr_rd_q;
  assign rob_wr_rd_we = rob_wr_rd_we_q;

`ifdef DISPATCH_ROB_ALLOC_STATS_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of cycles where the front end offers a group that cannot be taken.
  always_comb begin
    stall_d = stall_q;
    if (in_valid[0] && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/dispatch_rob_alloc.md
# dispatch_rob_alloc

Dispatch-side allocator for the reorder buffer. It accepts up to DISPATCH_WIDTH decoded instructions per cycle and assigns each one a ROB tag in program order. It writes the tagged entries into the ROB over a registered write port. It tracks ROB occupancy from its own allocations and from the retire count the ROB reports back, and throttles the front end when the ROB cannot absorb a full group.

## Interface
- DISPATCH_WIDTH, 2: instruction slots per dispatch group.
- RETIRE_WIDTH, 2: maximum entries the ROB frees per cycle.
- ROB_DEPTH, 16: ROB entries; must be a power of 2. TAG_W = $clog2(ROB_DEPTH).
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  DISPATCH_WIDTH  per-slot valid; slot 0 is oldest.
- in_ready  out  1  group accept.
- in_pc  in  DISPATCH_WIDTH*32  per-slot PC.
- in_rd  in  DISPATCH_WIDTH*5  per-slot destination architectural register.
- in_rd_we  in  DISPATCH_WIDTH  per-slot destination write enable.
- rob_wr_valid  out  DISPATCH_WIDTH  per-slot ROB write strobe.
- rob_wr_tag  out  DISPATCH_WIDTH*TAG_W  allocated tag per slot.
- rob_wr_pc, rob_wr_rd, rob_wr_rd_we  out  same widths as the in_* ports  registered copies of the accepted fields.
- retire_count  in  $clog2(RETIRE_WIDTH+1)  entries the ROB retired this cycle.
- flush  in  1  pipeline flush; empties the ROB.
- free_count  out  TAG_W+1  free ROB entries.
- tail_tag  out  TAG_W  next tag to be allocated.
- stall_cycles  out  32  front-end stall counter (see Configuration).

## Operation
- State: tail pointer (TAG_W bits, wraps modulo ROB_DEPTH) and occupancy counter (TAG_W+1 bits, range 0..ROB_DEPTH). free_count = ROB_DEPTH − occupancy.
- in_ready = !flush && (free_count >= DISPATCH_WIDTH).
- Transfer occurs when in_ready && in_valid[0].
- Allocated slots are the contiguous low-order prefix of in_valid. Valid bits above the first zero bit are ignored. An in_valid with bit 0 clear allocates nothing.
- On transfer with n allocated slots:
  - slot i receives tag (tail + i) mod ROB_DEPTH;
  - tail advances by n;
  - fields are captured into the rob_wr_* registers;
  - rob_wr_valid bit i = 1 for i < n.
- On a cycle without a transfer, rob_wr_valid = 0 the next cycle. Other rob_wr_* fields hold their previous values.
- Occupancy update: occupancy_next = occupancy + n − retire_count. Allocation and retirement in the same cycle are both applied.
- retire_count > occupancy is illegal. The bench asserts on it; the RTL clamps occupancy_next at 0.
- flush has priority over allocation and retirement:
  - next cycle, tail = 0, occupancy = 0, rob_wr_valid = 0;
  - retire_count in the flush cycle is ignored.
- Reset values: tail_tag = 0, free_count = ROB_DEPTH, rob_wr_valid = 0, rob_wr_tag / pc / rd / rd_we = 0, stall_cycles = 0. in_ready = 1 once rst deasserts (if flush is low).

## Timing
- Accept-to-ROB-write latency: 1 cycle. rob_wr_* is valid in the cycle after the transfer edge.
- in_ready is a function of registered occupancy and flush only. There is no combinational path from in_valid, in_* data or retire_count to in_ready.
- Entries freed by retire_count in cycle t are reflected in free_count, and can be allocated, from cycle t+1.
- free_count and tail_tag include allocations already accepted but still sitting in the rob_wr_* registers.
- Reset asserted mid-operation clears all state immediately (asynchronous). An in-flight rob_wr_valid drops without waiting for an edge.
- Tail wrap: after tag ROB_DEPTH−1 comes tag 0, including within a single group.

## Configuration
- DISPATCH_ROB_ALLOC_STATS_EN defined: stall_cycles increments by 1 on each cycle with in_valid[0] && !in_ready. It saturates at 0xFFFFFFFF and clears on rst.
- Not defined: the counter is not built and stall_cycles is tied to 0.

## Test plan
- Reset check: assert rst, then release -> free_count=16, tail_tag=0, rob_wr_valid=2'b00, in_ready=1.
- Fill: in_valid=2'b11 for 8 consecutive cycles with retire_count=0 -> tags 0..15 issued in pairs, each pair 1 cycle after its transfer. Then free_count=0, and in_ready=0 in the 9th cycle.
- Wrap: starting from full, pulse retire_count=2 -> next cycle free_count=2 and in_ready=1. A dispatch of 2'b11 then receives tags 0 and 1; tail_tag=2.
- Simultaneous events: occupancy 10, dispatch 2'b11 with retire_count=1 -> next cycle free_count=5. Then in_valid=2'b01 -> one tag allocated, rob_wr_valid=2'b01.
- Flush priority: occupancy 7, flush=1 with in_valid=2'b11 and retire_count=2 -> no transfer, in_ready=0 that cycle. Next cycle free_count=16, tail_tag=0, rob_wr_valid=0.
- Malformed group and stats: in_valid=2'b10 -> no allocation, tail unchanged. With DISPATCH_ROB_ALLOC_STATS_EN, holding in_valid=2'b11 for 3 cycles at free_count=1 -> stall_cycles=3.
